// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes and
// the datapath select encodings driven by the output decoder.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_RTYPEEX = 4'd6;
    localparam logic [3:0] ST_RTYPEWB = 4'd7;
    localparam logic [3:0] ST_BEQEX   = 4'd8;
    localparam logic [3:0] ST_BNEEX   = 4'd9;
    localparam logic [3:0] ST_ADDIEX  = 4'd10;
    localparam logic [3:0] ST_ORIEX   = 4'd11;
    localparam logic [3:0] ST_IMMWB   = 4'd12;
    localparam logic [3:0] ST_JEX     = 4'd13;
    localparam logic [3:0] ST_TRAP    = 4'd14;

    typedef enum logic [3:0] {
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_MEMADR  = ST_MEMADR,
        S_MEMRD   = ST_MEMRD,
        S_MEMWB   = ST_MEMWB,
        S_MEMWR   = ST_MEMWR,
        S_RTYPEEX = ST_RTYPEEX,
        S_RTYPEWB = ST_RTYPEWB,
        S_BEQEX   = ST_BEQEX,
        S_BNEEX   = ST_BNEEX,
        S_ADDIEX  = ST_ADDIEX,
        S_ORIEX   = ST_ORIEX,
        S_IMMWB   = ST_IMMWB,
        S_JEX     = ST_JEX,
        S_TRAP    = ST_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_decoded(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW)  ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_J)     || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the current state (and mem_ready for the
// handshake-qualified strobes) to every datapath select and write strobe.
module mc_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [1:0] branch,
    output logic       pcwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done
);

    // Per-state control word; everything not named for a state stays 0.
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        zeroext    = 1'b0;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALU;
        branch     = 2'b00;
        pcwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            ST_DECODE: begin
                alusrcb = SRCB_BRIMM;
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                mem_req    = 1'b1;
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            ST_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ST_RTYPEWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            ST_BEQEX, ST_BNEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = {1'b1, (state == ST_BNEEX)};
                instr_done = 1'b1;
            end
            ST_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ST_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                zeroext = 1'b1;
                aluop   = ALUOP_OR;
            end
            ST_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_JEX: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: state register, next-state logic, sticky
// illegal-op flag and the final PC enable. Outputs come from mc_outdec.
// Build option: MC_ILLEGAL_TRAP_EN sends undecoded opcodes to a TRAP state
// that sets illegal_op; without it they retire as a NOP from DECODE.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [1:0] branch,
    output logic       pcwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state;
    state_t state_nx;

    logic d_mem_req;
    logic d_memwrite;
    logic d_irwrite;
    logic d_pcwrite;
    logic d_regwrite;
    logic d_instr_done;
    logic nop_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_RTYPEEX;
                    OP_BEQ:       state_nx = S_BEQEX;
                    OP_BNE:       state_nx = S_BNEEX;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_ORI:       state_nx = S_ORIEX;
                    OP_J:         state_nx = S_JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_nx = S_TRAP;
`else
                    default:      state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_nx = S_FETCH;
            S_RTYPEEX: state_nx = S_RTYPEWB;
            S_ADDIEX:  state_nx = S_IMMWB;
            S_ORIEX:   state_nx = S_IMMWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:    state_nx = S_TRAP;
`endif
            default:   state_nx = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state      (state),
        .mem_ready  (mem_ready),
        .mem_req    (d_mem_req),
        .memwrite   (d_memwrite),
        .iord       (iord),
        .irwrite    (d_irwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .zeroext    (zeroext),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .branch     (branch),
        .pcwrite    (d_pcwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (d_regwrite),
        .instr_done (d_instr_done)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    assign nop_done = 1'b0;

    // Sticky trap flag: rises the cycle after TRAP is entered, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset)                 illegal_op <= 1'b0;
        else if (state == S_TRAP)  illegal_op <= 1'b1;
    end
`else
    // An undecoded opcode retires straight out of DECODE.
    assign nop_done   = (state == S_DECODE) && !op_decoded(op);
    assign illegal_op = 1'b0;
`endif

    // Reset masks every strobe so an aborted instruction writes nothing.
    assign mem_req    = ~reset & d_mem_req;
    assign memwrite   = ~reset & d_memwrite;
    assign irwrite    = ~reset & d_irwrite;
    assign pcwrite    = ~reset & d_pcwrite;
    assign regwrite   = ~reset & d_regwrite;
    assign instr_done = ~reset & (d_instr_done | nop_done);
    assign pcen       = ~reset & (d_pcwrite | (branch[1] & (zero ^ branch[0])));

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by
// cycle and compares the full output word against hand-derived values.
module tb_mc_controller;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                   T_MEMWB = 4, T_MEMWR = 5, T_RTYPEEX = 6, T_RTYPEWB = 7,
                   T_BEQEX = 8, T_BNEEX = 9, T_ADDIEX = 10, T_ORIEX = 11,
                   T_IMMWB = 12, T_JEX = 13, T_TRAP = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, memwrite, iord, irwrite, alusrca, zeroext;
    logic [1:0] alusrcb, aluop, pcsrc, branch;
    logic       pcwrite, pcen, regdst, memtoreg, regwrite, instr_done, illegal_op;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [20:0] obs;
    assign obs = {mem_req, memwrite, iord, irwrite, alusrca, alusrcb, zeroext,
                  aluop, pcsrc, branch, pcwrite, pcen, regdst, memtoreg,
                  regwrite, instr_done, illegal_op};

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
        .pcsrc(pcsrc), .branch(branch), .pcwrite(pcwrite), .pcen(pcen),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Expected output word for a state, written from the state table.
    function automatic logic [20:0] expv(input int st, input logic mr, input logic z,
                                         input logic nop, input logic ill, input logic rst);
        logic rq, mw, io, ir, sa, ze, pw, pe, rd, mt, rw, dn;
        logic [1:0] sb, ao, ps, br;
        {rq, mw, io, ir, sa, ze, pw, pe, rd, mt, rw, dn} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00; br = 2'b00;
        case (st)
            T_FETCH:   begin rq = 1; sb = 2'b01; ir = mr; pw = mr; end
            T_DECODE:  begin sb = 2'b11; dn = nop; end
            T_MEMADR:  begin sa = 1; sb = 2'b10; end
            T_MEMRD:   begin rq = 1; io = 1; end
            T_MEMWB:   begin rw = 1; mt = 1; dn = 1; end
            T_MEMWR:   begin rq = 1; mw = 1; io = 1; dn = mr; end
            T_RTYPEEX: begin sa = 1; ao = 2'b10; end
            T_RTYPEWB: begin rw = 1; rd = 1; dn = 1; end
            T_BEQEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; br = 2'b10; dn = 1; end
            T_BNEEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; br = 2'b11; dn = 1; end
            T_ADDIEX:  begin sa = 1; sb = 2'b10; end
            T_ORIEX:   begin sa = 1; sb = 2'b10; ze = 1; ao = 2'b11; end
            T_IMMWB:   begin rw = 1; dn = 1; end
            T_JEX:     begin ps = 2'b10; pw = 1; dn = 1; end
            default:   begin end
        endcase
        pe = pw | (br[1] & (z ^ br[0]));
        if (rst) {rq, mw, ir, pw, pe, rw, dn} = '0;
        return {rq, mw, io, ir, sa, sb, ze, ao, ps, br, pw, pe, rd, mt, rw, dn, ill};
    endfunction

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if (obs !== expv(T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", obs, expv(T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_lw();
        int seq[5];
        int done_cnt = 0;
        seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB};
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; zero = 1'b0; #1;
            done_cnt += int'(instr_done);
            n_cmp++;
            if (obs !== expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_sw_stall();
        int seq[7];
        logic mr[7];
        int done_cnt = 0;
        seq = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWR, T_MEMWR, T_MEMWR, T_MEMWR};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            done_cnt += int'(instr_done);
            n_cmp++;
            if (obs !== expv(seq[i], mr[i], 1'b0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL sw_stall cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], mr[i], 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL sw_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_addi_fetch_stall();
        int seq[6];
        logic mr[6];
        seq = '{T_FETCH, T_FETCH, T_FETCH, T_DECODE, T_ADDIEX, T_IMMWB};
        mr  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        op = 6'b001000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            n_cmp++;
            if (obs !== expv(seq[i], mr[i], 1'b0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL addi_stall cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], mr[i], 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] bop[4];
        logic       bz[4];
        logic       bpcen[4];
        int         bst[4];
        bop   = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
        bz    = '{1'b0, 1'b1, 1'b1, 1'b0};
        bpcen = '{1'b1, 1'b0, 1'b1, 1'b0};
        bst   = '{T_BNEEX, T_BNEEX, T_BEQEX, T_BEQEX};
        for (int k = 0; k < 4; k++) begin
            op = bop[k];
            @(negedge clk); mem_ready = 1'b1; zero = bz[k]; #1;
            n_cmp++;
            if (obs !== expv(T_FETCH, 1'b1, bz[k], 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL branch%0d fetch: got %h expected %h", k, obs, expv(T_FETCH, 1'b1, bz[k], 1'b0, 1'b0, 1'b0));
            end
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== expv(T_DECODE, 1'b1, bz[k], 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL branch%0d decode: got %h expected %h", k, obs, expv(T_DECODE, 1'b1, bz[k], 1'b0, 1'b0, 1'b0));
            end
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== expv(bst[k], 1'b1, bz[k], 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL branch%0d ex: got %h expected %h", k, obs, expv(bst[k], 1'b1, bz[k], 1'b0, 1'b0, 1'b0));
            end
            n_cmp++;
            if (pcen !== bpcen[k]) begin
                n_fail++;
                $display("FAIL branch%0d pcen: got %b expected %b", k, pcen, bpcen[k]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_ori_j();
        int seq[7];
        seq = '{T_FETCH, T_DECODE, T_ORIEX, T_IMMWB, T_FETCH, T_DECODE, T_JEX};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); mem_ready = 1'b1;
            op = (i < 4) ? 6'b001101 : 6'b000010;
            #1;
            n_cmp++;
            if (obs !== expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL ori_j cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_rtype_reset();
        int seq[3];
        seq = '{T_FETCH, T_DECODE, T_RTYPEEX};
        op = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_cmp++;
            if (obs !== expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL rtype cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++;
        if (obs !== expv(T_RTYPEWB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL rtype_wb_reset: got %h expected %h", obs, expv(T_RTYPEWB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        n_cmp++;
        if (regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL rtype_regwrite_in_reset: got %b expected 0", regwrite);
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL rtype_after_reset: got %h expected %h", obs, expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        int seq[5];
        logic il[5];
        seq = '{T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP};
        il  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_cmp++;
            if (obs !== expv(seq[i], 1'b1, 1'b0, 1'b0, il[i], 1'b0)) begin
                n_fail++;
                $display("FAIL illegal_trap cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], 1'b1, 1'b0, 1'b0, il[i], 1'b0));
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++;
        if (obs !== expv(T_TRAP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL illegal_trap_reset: got %h expected %h", obs, expv(T_TRAP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL illegal_trap_recover: got %h expected %h", obs, expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
`else
        int seq[2];
        seq = '{T_FETCH, T_DECODE};
        op = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_cmp++;
            if (obs !== expv(seq[i], 1'b1, 1'b0, (i == 1), 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL illegal_nop cycle %0d: got %h expected %h", i + 1, obs, expv(seq[i], 1'b1, 1'b0, (i == 1), 1'b0, 1'b0));
            end
        end
`endif
    endtask

    task automatic test_final_fetch();
        @(negedge clk); mem_ready = 1'b0; op = 6'b000000; #1;
        n_cmp++;
        if (obs !== expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL final_fetch: got %h expected %h", obs, expv(T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_addi_fetch_stall();
        test_branch();
        test_ori_j();
        test_rtype_reset();
        test_illegal();
        test_final_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
